// File: rtl/oled_pkg.sv
// Shared OLED geometry, level widths and peak-marker state encoding for the
// volume-bar display path.
package oled_pkg;

  localparam int OLED_W    = 96;
  localparam int OLED_H    = 64;
  localparam int LEVEL_W   = 5;
  localparam int LEVEL_MAX = 31;

  typedef logic [LEVEL_W-1:0] level_t;

  typedef enum logic [1:0] {
    TRACK,
    HOLD,
    FALL
  } peak_state_e;

endpackage

// File: rtl/volume_bar_controller_if.sv
// Sample/tick inputs, pixel request/response pair and level readback of the
// volume bar controller.
interface volume_bar_controller_if;
  import oled_pkg::*;

  logic       sample_valid;
  level_t     sample_level;
  logic       tick;
  logic       pix_valid;
  logic [6:0] pix_x;
  logic [5:0] pix_y;
  logic       bar_en;
  level_t     bar_coord;
  logic       pix_out_valid;
  level_t     disp_level;
  level_t     peak_level;

  modport master (
    output sample_valid, sample_level, tick, pix_valid, pix_x, pix_y,
    input  bar_en, bar_coord, pix_out_valid, disp_level, peak_level
  );

  modport slave (
    input  sample_valid, sample_level, tick, pix_valid, pix_x, pix_y,
    output bar_en, bar_coord, pix_out_valid, disp_level, peak_level
  );
endinterface

// File: rtl/volume_bar_controller_peak_tracker.sv
// Peak-hold marker: follows the display level, holds a new maximum for
// HOLD_TICKS ticks, then falls one level per DECAY_TICKS ticks.
module peak_tracker
  import oled_pkg::*;
#(
  parameter int HOLD_TICKS  = 50,
  parameter int DECAY_TICKS = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   tick,
  input  level_t disp_level_next,
  output level_t peak_level
);

  localparam int HCNT_W = $clog2(HOLD_TICKS + 1);
  localparam int PCNT_W = $clog2(DECAY_TICKS + 1);

  peak_state_e       state_q, state_d;
  level_t            peak_q, peak_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    peak_d  = peak_q;
    hcnt_d  = hcnt_q;
    pcnt_d  = pcnt_q;

    unique case (state_q)
      TRACK: peak_d = disp_level_next;
      HOLD: begin
        if (tick) begin
          if (hcnt_q == HCNT_W'(HOLD_TICKS - 1)) begin
            state_d = FALL;
            hcnt_d  = '0;
            pcnt_d  = '0;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end
      end
      FALL: begin
        if (tick) begin
          if (pcnt_q == PCNT_W'(DECAY_TICKS - 1)) begin
            peak_d = peak_q - 1'b1;
            pcnt_d = '0;
          end else begin
            pcnt_d = pcnt_q + 1'b1;
          end
        end
        // Once the falling marker meets the bar it rejoins it.
        if (peak_d <= disp_level_next) begin
          peak_d  = disp_level_next;
          state_d = TRACK;
          pcnt_d  = '0;
        end
      end
      default: state_d = TRACK;
    endcase

    // A new maximum restarts the hold from any state.
    if (disp_level_next > peak_q) begin
      peak_d  = disp_level_next;
      state_d = HOLD;
      hcnt_d  = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TRACK;
      peak_q  <= '0;
      hcnt_q  <= '0;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      peak_q  <= peak_d;
      hcnt_q  <= hcnt_d;
      pcnt_q  <= pcnt_d;
    end
  end

  assign peak_level = peak_q;

endmodule

// File: rtl/volume_bar_controller.sv
// Volume bar: instant-attack / timed-decay display level, peak marker, and a
// one-cycle pixel mapper feeding the gradient colour lookup.
module volume_bar_controller
  import oled_pkg::*;
#(
  parameter int BAR_X0      = 40,
  parameter int BAR_W       = 16,
  parameter int DECAY_TICKS = 4,
  parameter int HOLD_TICKS  = 50
) (
  input logic               clk,
  input logic               rst,
  volume_bar_controller_if.slave bus
);

  localparam int         DCNT_W = $clog2(DECAY_TICKS + 1);
  localparam logic [6:0] X_LO   = 7'(BAR_X0);
  localparam logic [6:0] X_HI   = 7'(BAR_X0 + BAR_W);

  level_t            target_q, target_d;
  level_t            disp_q, disp_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic              decay_step;
  level_t            peak_level;

  logic   bar_en_q, bar_en_d;
  level_t bar_coord_q, bar_coord_d;
  logic   pix_out_valid_q, pix_out_valid_d;
  level_t seg;
  logic   in_bar, marker_hit;
  logic   pix_row_lsb_unused;

  always_comb begin
    target_d   = target_q;
    disp_d     = disp_q;
    dcnt_d     = dcnt_q;
    decay_step = 1'b0;

    if (bus.tick && (disp_q > target_q)) begin
      if (dcnt_q == DCNT_W'(DECAY_TICKS - 1)) begin
        decay_step = 1'b1;
        disp_d     = disp_q - 1'b1;
        dcnt_d     = '0;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end

    // A fresh sample overrides any decay step landing in the same cycle.
    if (bus.sample_valid) begin
      target_d = bus.sample_level;
      disp_d   = (bus.sample_level > disp_q) ? bus.sample_level : disp_q;
      if (decay_step) dcnt_d = '0;
    end

    if (disp_d <= target_d) dcnt_d = '0;
  end

  peak_tracker #(
    .HOLD_TICKS (HOLD_TICKS),
    .DECAY_TICKS(DECAY_TICKS)
  ) u_peak (
    .clk            (clk),
    .rst            (rst),
    .tick           (bus.tick),
    .disp_level_next(disp_d),
    .peak_level     (peak_level)
  );

  // Two rows per segment, segment 31 at the top of the panel.
  assign seg                = level_t'(LEVEL_MAX) - bus.pix_y[5:1];
  assign pix_row_lsb_unused = bus.pix_y[0];
  assign in_bar             = (bus.pix_x >= X_LO) && (bus.pix_x < X_HI);
  assign marker_hit         = (peak_level != '0) && (seg == peak_level - 1'b1);

  always_comb begin
    bar_en_d        = bus.pix_valid && in_bar && ((seg < disp_q) || marker_hit);
    bar_coord_d     = bar_en_d ? seg : '0;
    pix_out_valid_d = bus.pix_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_q        <= '0;
      disp_q          <= '0;
      dcnt_q          <= '0;
      bar_en_q        <= 1'b0;
      bar_coord_q     <= '0;
      pix_out_valid_q <= 1'b0;
    end else begin
      target_q        <= target_d;
      disp_q          <= disp_d;
      dcnt_q          <= dcnt_d;
      bar_en_q        <= bar_en_d;
      bar_coord_q     <= bar_coord_d;
      pix_out_valid_q <= pix_out_valid_d;
    end
  end

  assign bus.bar_en        = bar_en_q;
  assign bus.bar_coord     = bar_coord_q;
  assign bus.pix_out_valid = pix_out_valid_q;
  assign bus.disp_level    = disp_q;
  assign bus.peak_level    = peak_level;

endmodule

// File: tb/tb_volume_bar_controller.sv
// Directed bench for volume_bar_controller: level checks inline, pixel
// responses checked against a queue of expected results.
module tb_volume_bar_controller;
  import oled_pkg::*;

  typedef struct {
    logic       en;
    logic [4:0] coord;
    int         due;
  } pix_exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  volume_bar_controller_if bus ();

  volume_bar_controller #(
    .BAR_X0     (40),
    .BAR_W      (16),
    .DECAY_TICKS(4),
    .HOLD_TICKS (50)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  pix_exp_t sb[$];
  pix_exp_t mon_e;
  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int exp_disp;
  int exp_peak;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic pix_exp_t exp_pix(input int x, input int y, input int disp,
                                       input int peak, input int due);
    pix_exp_t r;
    int  seg;
    bit  lit;
    seg     = 31 - y / 2;
    lit     = (x >= 40) && (x < 56) && ((seg < disp) || (peak != 0 && seg == peak - 1));
    r.en    = lit;
    r.coord = lit ? 5'(seg) : 5'd0;
    r.due   = due;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    bus.tick = 1'b1;
    repeat (n) step();
    bus.tick = 1'b0;
  endtask

  task automatic sample(input int v);
    bus.sample_valid = 1'b1;
    bus.sample_level = 5'(v);
    step();
    bus.sample_valid = 1'b0;
  endtask

  task automatic pixel(input int x, input int y);
    bus.pix_valid = 1'b1;
    bus.pix_x     = 7'(x);
    bus.pix_y     = 6'(y);
    sb.push_back(exp_pix(x, y, exp_disp, exp_peak, cyc + 1));
    step();
    bus.pix_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && bus.pix_out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("pix_unexpected", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("pix_en", bus.bar_en, mon_e.en);
        check("pix_coord", bus.bar_coord, mon_e.coord);
        check("pix_latency", cyc, mon_e.due);
      end
    end
  end

  initial begin
    rst              = 1'b1;
    bus.sample_valid = 1'b0;
    bus.sample_level = '0;
    bus.tick         = 1'b0;
    bus.pix_valid    = 1'b0;
    bus.pix_x        = '0;
    bus.pix_y        = '0;
    exp_disp         = 0;
    exp_peak         = 0;

    // Reset holds everything at zero even with a sample strobe.
    repeat (2) step();
    sample(20);
    step();
    check("rst_disp", bus.disp_level, 0);
    check("rst_peak", bus.peak_level, 0);
    check("rst_bar_en", bus.bar_en, 0);
    check("rst_coord", bus.bar_coord, 0);
    check("rst_pov", bus.pix_out_valid, 0);
    rst = 1'b0;
    step();
    pixel(45, 0);
    step();
    check("pov_idle", bus.pix_out_valid, 0);

    // Attack and pixel mapping, including column edges.
    sample(20);
    exp_disp = 20;
    exp_peak = 20;
    check("attack_disp", bus.disp_level, 20);
    check("attack_peak", bus.peak_level, 20);
    pixel(45, 63);
    pixel(45, 22);
    pixel(45, 24);
    pixel(39, 24);
    pixel(40, 24);
    pixel(55, 24);
    pixel(56, 24);
    pixel(100, 24);
    step();

    // Decay toward a lower target; peak holds then falls back to it.
    sample(10);
    check("decay_t0", bus.disp_level, 20);
    ticks(3);
    check("decay_t3", bus.disp_level, 20);
    ticks(1);
    check("decay_t4", bus.disp_level, 19);
    ticks(36);
    check("decay_t40", bus.disp_level, 10);
    ticks(100);
    check("decay_floor", bus.disp_level, 10);
    check("decay_peak_track", bus.peak_level, 10);
    exp_disp = 10;
    exp_peak = 10;

    // Peak hold and fall with the marker pixel.
    sample(20);
    sample(0);
    ticks(49);
    check("hold_t49_peak", bus.peak_level, 20);
    check("hold_t49_disp", bus.disp_level, 8);
    exp_disp = 8;
    exp_peak = 20;
    pixel(45, 24);
    pixel(45, 22);
    pixel(45, 50);
    ticks(1);
    check("fall_t50_peak", bus.peak_level, 20);
    ticks(4);
    check("fall_t54_peak", bus.peak_level, 19);
    check("fall_t54_disp", bus.disp_level, 7);
    exp_disp = 7;
    exp_peak = 19;
    pixel(45, 24);
    pixel(45, 26);
    ticks(75);
    check("fall_t129_peak", bus.peak_level, 1);
    check("fall_t129_disp", bus.disp_level, 0);
    ticks(1);
    check("fall_t130_peak", bus.peak_level, 0);

    // Sample collides with a decay-completing tick.
    sample(12);
    sample(11);
    ticks(3);
    check("sim_pre", bus.disp_level, 12);
    bus.tick         = 1'b1;
    bus.sample_valid = 1'b1;
    bus.sample_level = 5'd5;
    step();
    bus.tick         = 1'b0;
    bus.sample_valid = 1'b0;
    check("sim_disp", bus.disp_level, 12);
    ticks(3);
    check("sim_dcnt_cleared", bus.disp_level, 12);
    ticks(1);
    check("sim_first_step", bus.disp_level, 11);
    ticks(23);
    check("sim_t27", bus.disp_level, 6);
    ticks(1);
    check("sim_target", bus.disp_level, 5);
    ticks(40);
    check("sim_floor", bus.disp_level, 5);
    check("sim_peak", bus.peak_level, 7);

    // Reset mid-stream zeroes outputs at once; service resumes afterwards.
    bus.pix_valid = 1'b1;
    bus.pix_x     = 7'd45;
    bus.pix_y     = 6'd63;
    step();
    bus.pix_valid = 1'b0;
    check("pre_rst_en", bus.bar_en, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_en", bus.bar_en, 0);
    check("mid_rst_coord", bus.bar_coord, 0);
    check("mid_rst_pov", bus.pix_out_valid, 0);
    check("mid_rst_disp", bus.disp_level, 0);
    check("mid_rst_peak", bus.peak_level, 0);
    repeat (2) step();
    rst = 1'b0;
    step();
    sample(20);
    exp_disp = 20;
    exp_peak = 20;
    pixel(45, 63);
    pixel(45, 24);

    repeat (3) step();
    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/volume_bar_controller.md
Name: volume_bar_controller

Overview:
- Drives the 32-level volume-bar colour gradient on the 96x64 OLED.
- Takes one 5-bit volume sample per measurement strobe and applies instant attack with timed decay to produce a display level.
- Tracks a peak-hold marker with a hold/fall state machine.
- For every pixel request from the OLED scanner, produces the enable/coord pair consumed by the gradient colour lookup, one cycle later.

Parameters:
- BAR_X0, 40, first OLED column of the bar (0..95)
- BAR_W, 16, bar width in columns; BAR_X0+BAR_W <= 96
- DECAY_TICKS, 4, ticks per one-level decrement of display level and falling peak (>=1)
- HOLD_TICKS, 50, ticks the peak is held before falling (>=1)

Ports:
- clk, in, 1, system clock
- rst, in, 1, asynchronous active-high reset
- sample_valid, in, 1, one-cycle strobe: sample_level is valid
- sample_level, in, 5, measured volume 0..31
- tick, in, 1, one-cycle timebase strobe (~1 ms)
- pix_valid, in, 1, pixel request valid
- pix_x, in, 7, column 0..95
- pix_y, in, 6, row 0..63, row 0 = top
- bar_en, out, 1, enable to colour lookup; 0 = black pixel
- bar_coord, out, 5, segment index to colour lookup
- pix_out_valid, out, 1, bar_en/bar_coord valid (pix_valid delayed 1 cycle)
- disp_level, out, 5, current displayed level
- peak_level, out, 5, current peak marker level

Behaviour:
- Reset is asynchronous and active-high. All of the following are 0 while rst is asserted and on its release: disp_level, peak_level, target, decay and hold counters, bar_en, bar_coord, pix_out_valid. Peak state is TRACK.
- Sample latch:
  - On sample_valid, target <= sample_level.
  - If sample_level > disp_level, disp_level <= sample_level in the same cycle (attack).
- Display decay:
  - dcnt counts ticks only while disp_level > target. When disp_level <= target, dcnt is cleared.
  - When a tick arrives with dcnt == DECAY_TICKS-1: disp_level decrements by 1 and dcnt clears.
  - disp_level never goes below target. No wrap at 0.
- If sample_valid and a decay step occur in the same cycle, the attack/latch wins and the decay step is dropped. dcnt is cleared in that cycle.
- Peak FSM states: TRACK, HOLD, FALL.
  - Any state: if the next disp_level > peak_level, then peak_level <= next disp_level, state goes to HOLD, and hcnt clears. This rule has highest priority.
  - TRACK: peak_level follows disp_level.
  - HOLD: hcnt increments on tick. A tick with hcnt == HOLD_TICKS-1 moves the state to FALL and clears pcnt.
  - FALL: pcnt increments on tick. A tick with pcnt == DECAY_TICKS-1 decrements peak_level and clears pcnt. When peak_level <= disp_level, peak_level <= disp_level and the state goes to TRACK.
  - peak_level is never below disp_level at any cycle boundary.
- Pixel mapping (registered, latency exactly 1 cycle, one result per cycle, no stall):
  - seg = 31 - pix_y[5:1], i.e. 2 rows per segment with segment 31 at the top.
  - in_bar = BAR_X0 <= pix_x < BAR_X0+BAR_W.
  - bar_en = pix_valid & in_bar & ((seg < disp_level) | (peak_level != 0 & seg == peak_level-1)).
  - bar_coord = seg when bar_en = 1, otherwise 0.
  - pix_out_valid = pix_valid delayed by 1 cycle.
  - Pixel lookups use the disp_level/peak_level values registered at the request cycle.
- Out-of-range pix_x (>= 96) yields bar_en = 0.
- Assertion of rst mid-frame immediately zeroes all outputs. The first request after release is served normally.

Decomposition:
- Shared package oled_pkg holds:
  - OLED_W=96, OLED_H=64, LEVEL_W=5, LEVEL_MAX=31
  - peak state enum {TRACK, HOLD, FALL}
- Sub-module peak_tracker holds the peak FSM with hcnt and pcnt. Inputs: clk, rst, tick, disp_level_next. Output: peak_level.
- The top level holds the attack/decay logic and the pixel mapper.

Test Plan:
- Reset: with rst held, pulse sample_valid level 20. Outputs stay 0. Release, then request pixel (45,0): bar_en=0, pix_out_valid=1 one cycle after the request.
- Attack: sample 20 → disp_level=20 on the next clock. Pixel (45,63) gives bar_en=1, coord=0. Pixel (45,22) (seg 20) gives bar_en=0. Pixel (45,24) (seg 19) gives bar_en=1, coord=19.
- Decay: after 20, sample 10 with DECAY_TICKS=4. disp_level reaches 19 after 4 ticks and 10 after 40 ticks, then holds at 10 for 100 further ticks.
- Peak hold/fall: after sample 20 then sample 0 (HOLD_TICKS=50, DECAY_TICKS=4):
  - peak_level=20 through tick 49; FALL starts at tick 50.
  - Peak decrements every 4 ticks and returns to TRACK at disp_level.
  - Marker pixel seg 19 is lit, coord=19, while disp_level < 20.
- Simultaneous: sample_valid(5) in the same cycle as a decay-completing tick from disp 12. disp_level stays 12, target=5, dcnt=0.
- Column edges: pix_x=39 and 56 give bar_en=0; 40 and 55 are lit when the segment is active. pix_x=100 gives bar_en=0.
